// File: rtl/mmio_port_hub.sv
// Memory-mapped I/O hub with debounced input channels, output registers,
// per-input change flags, an interrupt mask and a level interrupt.
// The bus side is single-cycle: read data is combinational from registered
// state, and every side effect takes place on the rising edge of cpu_clk.
module mmio_port_hub #(
   parameter int          IN_CH        = 2,
   parameter int          OUT_CH       = 2,
   parameter int          CH_W         = 16,
   parameter logic [31:0] BASE_ADDR    = 32'hFFFF_FC00,
   parameter int          DEBOUNCE_CYC = 16
) (
   input  logic                   cpu_clk,
   input  logic                   reset,
   input  logic [31:0]            addr,
   input  logic                   io_read,
   input  logic                   io_write,
   input  logic [31:0]            wdata,
   output logic [31:0]            rdata,
   output logic                   hit,
   input  logic [IN_CH*CH_W-1:0]  sw_in,
   output logic [OUT_CH*CH_W-1:0] led_out,
   output logic                   irq
);
   localparam int               CNT_W    = $clog2(DEBOUNCE_CYC) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   // Word indices (byte offset >> 2) inside the 256-byte region.
   localparam logic [5:0] W_OUT    = 6'h18;
   localparam logic [5:0] W_IN     = 6'h1C;
   localparam logic [5:0] W_STATUS = 6'h20;
   localparam logic [5:0] W_MASK   = 6'h21;

   logic [CH_W-1:0]   out_reg [OUT_CH];
   logic [CH_W-1:0]   sync1   [IN_CH];
   logic [CH_W-1:0]   sync2   [IN_CH];
   logic [CH_W-1:0]   sync2_d [IN_CH];
   logic [CH_W-1:0]   stable  [IN_CH];
   logic [CNT_W-1:0]  cnt     [IN_CH];
   logic [IN_CH-1:0]  chg_flag;
   logic [IN_CH-1:0]  chg_set;
   logic [IN_CH-1:0]  irq_mask;
   logic              region;
   logic [5:0]        word;
   logic [OUT_CH-1:0] sel_out;
   logic [IN_CH-1:0]  sel_in;
   logic              sel_status;
   logic              sel_mask;
   logic              status_clr;
   logic              unused_bits;

   // Byte lanes and wide store data above the channel width are don't-care.
   assign unused_bits = ^{addr[1:0], wdata};

   assign region     = (addr[31:8] == BASE_ADDR[31:8]);
   assign word       = addr[7:2];
   assign sel_status = region && (word == W_STATUS);
   assign sel_mask   = region && (word == W_MASK);
   assign hit        = (|sel_out) | (|sel_in) | sel_status | sel_mask;
   assign status_clr = io_read && sel_status;
   assign irq        = |(chg_flag & irq_mask);

   // Per-channel register selects; channels beyond IN_CH/OUT_CH stay unmapped.
   always_comb begin
      sel_out = '0;
      sel_in  = '0;
      for (int k = 0; k < OUT_CH; k++) sel_out[k] = region && (word == W_OUT + 6'(k));
      for (int k = 0; k < IN_CH; k++)  sel_in[k]  = region && (word == W_IN + 6'(k));
   end

   // Load data mux, zero unless a mapped register is being read.
   always_comb begin
      rdata = '0;
      if (io_read) begin
         for (int k = 0; k < OUT_CH; k++) if (sel_out[k]) rdata = 32'(out_reg[k]);
         for (int k = 0; k < IN_CH; k++)  if (sel_in[k])  rdata = 32'(stable[k]);
         if (sel_status) rdata = 32'(chg_flag);
         if (sel_mask)   rdata = 32'(irq_mask);
      end
   end

   // Pack the output registers onto the pins.
   always_comb begin
      led_out = '0;
      for (int k = 0; k < OUT_CH; k++) led_out[k*CH_W +: CH_W] = out_reg[k];
   end

   // A channel accepts its new value when sync2 has differed from stable and
   // held steady for DEBOUNCE_CYC consecutive edges.
   always_comb begin
      chg_set = '0;
      for (int k = 0; k < IN_CH; k++)
         chg_set[k] = (sync2[k] != stable[k]) && (sync2[k] == sync2_d[k]) && (cnt[k] == CNT_LAST);
   end

   // Synchroniser, debounce counter, stable value and change flags.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         for (int k = 0; k < IN_CH; k++) begin
            sync1[k]   <= '0;
            sync2[k]   <= '0;
            sync2_d[k] <= '0;
            stable[k]  <= '0;
            cnt[k]     <= '0;
         end
         chg_flag <= '0;
      end else begin
         for (int k = 0; k < IN_CH; k++) begin
            sync1[k]   <= sw_in[k*CH_W +: CH_W];
            sync2[k]   <= sync1[k];
            sync2_d[k] <= sync2[k];
            if (sync2[k] == stable[k] || sync2[k] != sync2_d[k] || chg_set[k])
               cnt[k] <= '0;
            else
               cnt[k] <= cnt[k] + 1'b1;
            if (chg_set[k]) stable[k] <= sync2[k];
         end
         // A flag setting on the same edge as a STATUS read survives the clear.
         chg_flag <= (status_clr ? '0 : chg_flag) | chg_set;
      end
   end

   // CPU stores to the output registers and the interrupt mask.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         for (int k = 0; k < OUT_CH; k++) out_reg[k] <= '0;
         irq_mask <= '0;
      end else if (io_write) begin
         for (int k = 0; k < OUT_CH; k++) if (sel_out[k]) out_reg[k] <= wdata[CH_W-1:0];
         if (sel_mask) irq_mask <= wdata[IN_CH-1:0];
      end
   end

endmodule

// File: tb/tb_mmio_port_hub.sv
// Bench for mmio_port_hub: directed scenarios with literal expectations plus
// randomized bus and pin traffic, all compared every cycle against a
// sliding-window behavioural model of the hub.
module tb_mmio_port_hub;
   localparam int          D = 4;
   localparam logic [31:0] B = 32'hFFFF_FC00;

   logic        cpu_clk = 1'b0;
   logic        reset, io_read, io_write, hit, irq;
   logic [31:0] addr, wdata, rdata, sw_in, led_out;

   logic        b_reset, b_read, b_write, b_hit, b_irq;
   logic [31:0] b_addr, b_wdata, b_rdata, b_sw, b_led;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state: pin sample history (index 0 = newest), accepted values,
   // output registers, flags and mask.
   logic [15:0] m_hist   [2][D+2];
   logic [15:0] m_stable [2];
   logic [15:0] m_led    [2];
   logic [1:0]  m_flag, m_mask;
   logic        model_valid = 1'b0;

   always #5 cpu_clk = ~cpu_clk;

   mmio_port_hub #(.IN_CH(2), .OUT_CH(2), .CH_W(16), .BASE_ADDR(B), .DEBOUNCE_CYC(D)) dut (
      .cpu_clk(cpu_clk), .reset(reset), .addr(addr), .io_read(io_read), .io_write(io_write),
      .wdata(wdata), .rdata(rdata), .hit(hit), .sw_in(sw_in), .led_out(led_out), .irq(irq));

   mmio_port_hub #(.IN_CH(4), .OUT_CH(4), .CH_W(8), .BASE_ADDR(B), .DEBOUNCE_CYC(1)) dut_b (
      .cpu_clk(cpu_clk), .reset(b_reset), .addr(b_addr), .io_read(b_read), .io_write(b_write),
      .wdata(b_wdata), .rdata(b_rdata), .hit(b_hit), .sw_in(b_sw), .led_out(b_led), .irq(b_irq));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // 0/1 = OUT[k], 2/3 = IN[k-2], 4 = STATUS, 5 = MASK, -1 = unmapped.
   function automatic int dec(input logic [31:0] a);
      if (a[31:8] != 24'hFFFFFC) return -1;
      case (a[7:0] & 8'hFC)
         8'h60:   return 0;
         8'h64:   return 1;
         8'h70:   return 2;
         8'h74:   return 3;
         8'h80:   return 4;
         8'h84:   return 5;
         default: return -1;
      endcase
   endfunction

   function automatic logic [31:0] exp_rdata();
      int c;
      c = dec(addr);
      if (!io_read) return 32'h0;
      case (c)
         0, 1:    return {16'h0, m_led[c]};
         2, 3:    return {16'h0, m_stable[c-2]};
         4:       return {30'h0, m_flag};
         5:       return {30'h0, m_mask};
         default: return 32'h0;
      endcase
   endfunction

   // Advance the model by one rising edge using the inputs present at it.
   task automatic model_edge();
      logic [1:0] set;
      logic       same;
      int         c;
      if (reset) begin
         for (int ch = 0; ch < 2; ch++) begin
            m_stable[ch] = '0;
            m_led[ch]    = '0;
            for (int i = 0; i < D + 2; i++) m_hist[ch][i] = '0;
         end
         m_flag = '0;
         m_mask = '0;
      end else begin
         set = '0;
         for (int ch = 0; ch < 2; ch++) begin
            // Accept when the last D+1 synchronised samples agree and differ.
            same = 1'b1;
            for (int i = 2; i <= D + 1; i++) if (m_hist[ch][i] != m_hist[ch][1]) same = 1'b0;
            if (same && m_hist[ch][1] != m_stable[ch]) begin
               set[ch]      = 1'b1;
               m_stable[ch] = m_hist[ch][1];
            end
         end
         c = dec(addr);
         m_flag = (io_read && c == 4) ? set : (m_flag | set);
         if (io_write && (c == 0 || c == 1)) m_led[c] = wdata[15:0];
         if (io_write && c == 5) m_mask = wdata[1:0];
         for (int ch = 0; ch < 2; ch++) begin
            for (int i = D + 1; i > 0; i--) m_hist[ch][i] = m_hist[ch][i-1];
            m_hist[ch][0] = sw_in[ch*16 +: 16];
         end
      end
   endtask

   task automatic check_outputs();
      chk("led_out", led_out, {m_led[1], m_led[0]});
      chk("irq", 32'(irq), 32'(|(m_flag & m_mask)));
      chk("hit", 32'(hit), 32'(dec(addr) >= 0));
      chk("rdata", rdata, exp_rdata());
   endtask

   // Inputs are driven after the falling edge; outputs are compared just
   // before the rising edge, then the model takes the edge.
   task automatic step();
      #1;
      if (model_valid) check_outputs();
      @(posedge cpu_clk);
      model_edge();
      model_valid = 1'b1;
      @(negedge cpu_clk);
   endtask

   task automatic idle();
      io_read  = 1'b0;
      io_write = 1'b0;
      addr     = 32'h0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      io_read  = 1'b0;
      io_write = 1'b1;
      addr     = a;
      wdata    = d;
      step();
      idle();
   endtask

   task automatic rd(input logic [31:0] a);
      io_read  = 1'b1;
      io_write = 1'b0;
      addr     = a;
      #1;
   endtask

   function automatic logic [31:0] pick_addr();
      logic [7:0] offs [12];
      offs = '{8'h60, 8'h64, 8'h68, 8'h6C, 8'h70, 8'h74, 8'h78, 8'h80, 8'h84, 8'h88, 8'h00, 8'hFC};
      if ($urandom_range(0, 15) == 0) return $urandom;
      return B + 32'(offs[$urandom_range(0, 11)]) + 32'($urandom_range(0, 3));
   endfunction

   initial begin
      reset = 1'b1; io_read = 1'b0; io_write = 1'b0; addr = '0; wdata = '0;
      sw_in = 32'hFFFF_FFFF;
      b_reset = 1'b1; b_read = 1'b0; b_write = 1'b0; b_addr = '0; b_wdata = '0;
      b_sw = 32'h4433_2211;

      // Reset with pins high.
      repeat (3) step();
      chk("rst_led", led_out, 32'h0);
      chk("rst_irq", 32'(irq), 32'h0);
      rd(B + 32'h70);
      chk("rst_in0", rdata, 32'h0);
      step();
      reset = 1'b0; b_reset = 1'b0;
      repeat (D + 2) step();
      chk("in0_before_accept", rdata, 32'h0);
      step();
      chk("in0_after_accept", rdata, 32'h0000_FFFF);
      rd(B + 32'h80);
      chk("status_both", rdata, 32'h3);
      step();
      chk("status_cleared", rdata, 32'h0);
      idle();

      // Output register store and an unmapped store.
      wr(B + 32'h64, 32'hDEAD_1234);
      chk("led_store", led_out, 32'h1234_0000);
      io_write = 1'b1; addr = B + 32'h68; wdata = 32'hFFFF_FFFF; #1;
      chk("unmapped_hit", 32'(hit), 32'h0);
      step();
      idle();
      chk("led_unchanged", led_out, 32'h1234_0000);

      // Debounce: settle channel 0 at 0, then step to 00A5.
      sw_in[15:0] = 16'h0;
      repeat (D + 6) step();
      rd(B + 32'h80);
      chk("status_ch0_fall", rdata, 32'h1);
      step();
      sw_in[15:0] = 16'h00A5;
      rd(B + 32'h70);
      repeat (6) step();
      chk("deb_edge6", rdata, 32'h0);
      step();
      chk("deb_edge7", rdata, 32'h0000_00A5);
      rd(B + 32'h80);
      chk("deb_status", rdata, 32'h1);
      step();

      // Three-cycle glitch never reaches the stable value.
      idle();
      sw_in[15:0] = 16'h00FF;
      repeat (3) step();
      sw_in[15:0] = 16'h00A5;
      repeat (D + 6) step();
      rd(B + 32'h70);
      chk("glitch_in0", rdata, 32'h0000_00A5);
      rd(B + 32'h80);
      chk("glitch_status", rdata, 32'h0);
      step();

      // Interrupt on channel 0 with MASK=01 (upper store bits ignored).
      idle();
      wr(B + 32'h84, 32'hFFFF_FFFD);
      sw_in[15:0] = 16'h1111;
      repeat (D + 2) step();
      chk("irq_pre", 32'(irq), 32'h0);
      step();
      chk("irq_set", 32'(irq), 32'h1);
      rd(B + 32'h80);
      chk("irq_status", rdata, 32'h1);
      step();
      chk("irq_clear", 32'(irq), 32'h0);
      chk("status_second", rdata, 32'h0);
      step();

      // Flag1 sets on the same edge as a STATUS read with flag0 pending.
      idle();
      sw_in[15:0] = 16'h2222;
      repeat (D + 4) step();
      sw_in[31:16] = 16'h3333;
      repeat (D + 2) step();
      rd(B + 32'h80);
      chk("collide_read", rdata, 32'h1);
      step();
      #1;
      chk("collide_after", rdata, 32'h2);
      idle();

      // Mask changes move irq without touching the flags.
      wr(B + 32'h84, 32'h2);
      chk("irq_mask_ch1", 32'(irq), 32'h1);
      wr(B + 32'h84, 32'h0);
      chk("irq_mask_zero", 32'(irq), 32'h0);

      // Randomized traffic against the model.
      for (int cyc = 0; cyc < 1500; cyc++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 8)       sw_in[15:0]  = 16'($urandom);
         else if (r < 16) sw_in[31:16] = 16'($urandom);
         reset    = ($urandom_range(0, 199) == 0);
         io_read  = 1'($urandom_range(0, 1));
         io_write = ($urandom_range(0, 3) == 0);
         addr     = pick_addr();
         wdata    = $urandom;
         step();
      end
      reset = 1'b0;
      idle();
      step();

      // Four-channel, 8-bit instance: every data register addressable.
      for (int k = 0; k < 4; k++) begin
         b_write = 1'b1;
         b_addr  = B + 32'h60 + 32'(4 * k);
         b_wdata = 32'hABCD_EF00 | 32'(8'hA0 + 8'(k));
         step();
      end
      b_write = 1'b0;
      chk("b_led", b_led, 32'hA3A2_A1A0);
      b_read = 1'b1;
      for (int k = 0; k < 4; k++) begin
         b_addr = B + 32'h60 + 32'(4 * k);
         #1;
         chk("b_out_rd", b_rdata, 32'h0000_00A0 + 32'(k));
         step();
      end
      for (int k = 0; k < 4; k++) begin
         b_addr = B + 32'h70 + 32'(4 * k);
         #1;
         chk("b_in_rd", b_rdata, 32'h11 * 32'(k + 1));
         step();
      end
      b_addr = B + 32'h88;
      #1;
      chk("b_unmapped_hit", 32'(b_hit), 32'h0);
      chk("b_unmapped_rdata", b_rdata, 32'h0);
      step();
      b_addr = B + 32'h80;
      #1;
      chk("b_status", b_rdata, 32'hF);
      chk("b_irq", 32'(b_irq), 32'h0);
      step();
      b_read = 1'b0;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mmio_port_hub.md
# mmio_port_hub

Parametrised memory-mapped I/O hub that replaces the fixed single switch port and single LED port with up to four debounced input channels and up to four output channels. Adds per-input change flags, an interrupt mask and a level interrupt line. Sits between the CPU's I/O read/write strobes and ALU-computed address on one side and the board pins on the other. Serves a single-cycle core: read data is combinational from registered state, and all side effects occur on the clock edge.

## Interface
- `IN_CH`, default 2: number of input channels, 1..4.
- `OUT_CH`, default 2: number of output channels, 1..4.
- `CH_W`, default 16: channel width in bits, 1..32.
- `BASE_ADDR`, default 32'hFFFF_FC00: I/O region base; bits [7:0] must be 0.
- `DEBOUNCE_CYC`, default 16: consecutive stable cycles required to accept an input change, ≥1.

Ports:
- `cpu_clk`  in  1: the only clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `addr`  in  32: byte address from the ALU result.
- `io_read`  in  1: I/O load strobe.
- `io_write`  in  1: I/O store strobe.
- `wdata`  in  32: store data.
- `rdata`  out  32: load data, combinational.
- `hit`  out  1: combinational; `addr` decodes to a mapped register.
- `sw_in`  in  IN_CH*CH_W: asynchronous pins; channel k occupies bits [k*CH_W +: CH_W].
- `led_out`  out  OUT_CH*CH_W: output registers, same packing.
- `irq`  out  1: |(chg_flag & irq_mask).

## Operation
Register map (offsets from BASE_ADDR):
- 0x60+4k: OUT[k], read/write, k<OUT_CH.
- 0x70+4k: IN[k], read-only; returns debounced stable value, k<IN_CH.
- 0x80: STATUS, bits[IN_CH-1:0]=chg_flag. Read clears.
- 0x84: MASK, bits[IN_CH-1:0]=irq_mask, read/write.

Decode:
- Word match on `addr[31:2]`; `addr[1:0]` ignored.
- Offsets for channels ≥ IN_CH/OUT_CH, and any other offset, are unmapped: `hit`=0, `rdata`=0, writes ignored.

Read and write:
- `rdata` is zero-extended from CH_W or IN_CH bits.
- `rdata`=0 whenever `io_read`=0 or the address is unmapped.
- Writes store `wdata[CH_W-1:0]` (OUT) or `wdata[IN_CH-1:0]` (MASK). Upper bits are ignored.
- `io_read` and `io_write` both high: the write executes, and `rdata` shows the pre-edge value.

Per input channel (sync1, sync2, sync2_d, stable, cnt, chg_flag):
- sync1<=pin; sync2<=sync1; sync2_d<=sync2.
- If sync2==stable or sync2!=sync2_d: cnt<=0.
- Else if cnt==DEBOUNCE_CYC-1: stable<=sync2, cnt<=0, chg_flag<=1.
- Else: cnt<=cnt+1.
- cnt width is clog2(DEBOUNCE_CYC)+1 and never wraps.

STATUS clear:
- An edge with `io_read` & STATUS selected clears all chg_flag bits.
- If a flag sets on that same edge, set wins for that bit; other bits clear.

## Timing
Reset values (any edge with `reset`=1):
- sync*, stable, cnt, chg_flag, OUT[*] and MASK are all 0.
- Therefore `led_out`=0 and `irq`=0 after the edge.
- Reset overrides all concurrent reads and writes.
- Reset mid-debounce discards the pending change. A pin held high through reset is re-accepted afterwards with full latency.

Latencies:
- OUT write: `led_out` updates on the same edge as the store. Latency 1 edge, no bubble; back-to-back stores are fine.
- Input: pin changes before edge E1 and holds. stable and chg_flag update on edge E(DEBOUNCE_CYC+3). For DEBOUNCE_CYC=1, that is E4.
- A glitch shorter than DEBOUNCE_CYC+1 cycles at sync2 never reaches stable.
- IN read: returns stable as of the last edge.
- `irq`: combinational from registers, so it rises in the cycle after the flag-setting edge and falls after the clearing edge or after a MASK write of 0.

## Test plan
- **Reset.** Pulse `reset` with pins=16'hFFFF → `led_out`=0, `irq`=0, all reads 0 during reset. IN[0]=16'hFFFF appears only DEBOUNCE_CYC+3 edges after `reset` drops.
- **LED store.** Store 32'hDEAD_1234 to 0xFFFF_FC64 (OUT_CH=2, CH_W=16) → `led_out`[31:16]=16'h1234 after that edge; OUT[0] unchanged. Store to 0xFFFF_FC68 → `hit`=0, no change.
- **Debounce, DEBOUNCE_CYC=4.** Step sw_in[15:0] 0→16'h00A5 → IN[0] reads 0 through edge 6, then 16'h00A5 from edge 7; STATUS bit0=1. A 3-cycle pulse → IN[0] never changes, STATUS=0.
- **Interrupt.** MASK=2'b01, change channel 0 → `irq`=1. Load STATUS returns 1, `irq`=0 next cycle, and a second STATUS read returns 0.
- **Set/clear collision.** Arrange the channel-1 flag-setting edge to coincide with a STATUS read while flag0=1 → read returns 2'b01; afterwards STATUS=2'b10.
- **Parameter sweep.** IN_CH=4, OUT_CH=4, CH_W=8: all 8 data registers are independently addressable, and `rdata`[31:8]=0 on every read.
